// File: rtl/branch_stall_ctrl.sv
// branch_stall_ctrl
//   Stall/flush controller for the ID-stage branch comparator of the 5-stage
//   MIPS pipeline. It holds IF/ID and injects an ID/EX bubble while a branch
//   (or a load-use consumer) waits on an operand that is not yet available.
//   It flushes IF/ID on taken branches and on jumps. Saturating counters
//   record stalled cycles and flushes.
//
// Ports
//   clk, rst_n          rising-edge clock, synchronous active-low reset
//   id_rs, id_rt        source register fields of the ID instruction
//   id_uses_rt          ID instruction reads rt
//   id_is_branch        ID instruction is a conditional branch
//   id_is_jump          ID instruction is j/jal/jr
//   branch_taken        ID comparator result (meaningful with id_is_branch)
//   ex_rw, ex_regWr     EX destination register / register-write enable
//   ex_memtoreg         EX writeback select (2'd1 = load)
//   mem_rw              MEM destination register
//   mem_memtoreg        MEM writeback select (2'd1 = load)
//   pc_write            PC enable
//   ifid_write          IF/ID enable
//   ifid_flush          zero IF/ID on the next edge
//   idex_bubble         load a NOP into ID/EX on the next edge
//   stall_active        not in RUN, or a stall is requested this cycle
//   stall_cycles        saturating count of bubbled cycles
//   flush_count         saturating count of flushes
module branch_stall_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_is_branch,
  input  logic             id_is_jump,
  input  logic             branch_taken,
  input  logic [4:0]       ex_rw,
  input  logic             ex_regWr,
  input  logic [1:0]       ex_memtoreg,
  input  logic [4:0]       mem_rw,
  input  logic [1:0]       mem_memtoreg,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             stall_active,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    STALL2 = 2'd1,
    STALL1 = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;

  logic       ex_is_load, ex_writes, mem_is_load;
  logic       rs_ex, rt_ex, rs_mem, rt_mem;
  logic       ex_load_hit, ex_alu_hit, mem_load_hit;
  logic [1:0] need_n;

  // Hazard detection: number of stall cycles the ID instruction needs.
  always_comb begin
    ex_is_load  = (ex_memtoreg == 2'd1);
    ex_writes   = ex_regWr || ex_is_load;
    mem_is_load = (mem_memtoreg == 2'd1);

    rs_ex  = (id_rs != 5'd0) && (id_rs == ex_rw) && ex_writes;
    rt_ex  = id_uses_rt && (id_rt != 5'd0) && (id_rt == ex_rw) && ex_writes;
    rs_mem = (id_rs != 5'd0) && (id_rs == mem_rw) && mem_is_load;
    rt_mem = id_uses_rt && (id_rt != 5'd0) && (id_rt == mem_rw) && mem_is_load;

    ex_load_hit  = (rs_ex || rt_ex) && ex_is_load;
    ex_alu_hit   = (rs_ex || rt_ex) && !ex_is_load;
    mem_load_hit = rs_mem || rt_mem;

    need_n = 2'd0;
    if (id_is_branch) begin
      if (ex_load_hit)       need_n = 2'd2;
      else if (ex_alu_hit)   need_n = 2'd1;
      else if (mem_load_hit) need_n = 2'd1;
    end else if (ex_load_hit) begin
      need_n = 2'd1;
    end
  end

  // FSM next state and outputs: Mealy in RUN, Moore in the stall states.
  always_comb begin
    state_d      = RUN;
    pc_write     = 1'b0;
    ifid_write   = 1'b0;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b1;
    stall_active = 1'b1;

    case (state_q)
      RUN: begin
        if (need_n != 2'd0) begin
          state_d = (need_n == 2'd2) ? STALL1 : RUN;
        end else begin
          pc_write     = 1'b1;
          ifid_write   = 1'b1;
          idex_bubble  = 1'b0;
          stall_active = 1'b0;
          ifid_flush   = id_is_jump || (id_is_branch && branch_taken);
        end
      end
      // Reserved state: acts as one extra stall cycle before STALL1.
      STALL2:  state_d = STALL1;
      STALL1:  state_d = RUN;
      default: state_d = RUN;
    endcase

    // Reset forces a safe output set regardless of state.
    if (!rst_n) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      ifid_flush   = 1'b0;
      idex_bubble  = 1'b1;
      stall_active = 1'b0;
    end
  end

  // Saturating performance counters.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (idex_bubble && (stall_cycles_q != '1))
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    if (ifid_flush && (flush_count_q != '1))
      flush_count_d = flush_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= RUN;
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;

endmodule

// File: doc/branch_stall_ctrl.md
Name: branch_stall_ctrl

Overview:
- Stall/flush controller for the ID-stage branch comparator in the 5-stage MIPS pipeline.
- Works alongside the branch forwarding selector. The forwarding selector picks a source for an operand that is already available; this block stalls IF/ID and bubbles ID/EX when an operand a branch needs is not yet available.
- Also flushes the IF/ID register on taken branches and jumps.
- Keeps saturating stall and flush counters for performance monitoring.

Parameters:
- CNT_W, 16, width of the stall_cycles and flush_count counters.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- id_uses_rt  in  1  the ID instruction reads rt (beq/bne/R-type).
- id_is_branch  in  1  the ID instruction is a conditional branch.
- id_is_jump  in  1  the ID instruction is j/jal/jr.
- branch_taken  in  1  ID comparator result; valid only when id_is_branch=1.
- ex_rw  in  5  destination register of the instruction in EX.
- ex_regWr  in  1  the EX instruction writes a register.
- ex_memtoreg  in  2  EX writeback select; 2'd1 = load.
- mem_rw  in  5  destination register of the instruction in MEM.
- mem_memtoreg  in  2  MEM writeback select; 2'd1 = load.
- pc_write  out  1  PC enable.
- ifid_write  out  1  IF/ID enable.
- ifid_flush  out  1  zero IF/ID on the next edge.
- idex_bubble  out  1  load a NOP into ID/EX on the next edge.
- stall_active  out  1  FSM is not in RUN, or a stall is asserted this cycle.
- stall_cycles  out  CNT_W  saturating count of stalled cycles.
- flush_count  out  CNT_W  saturating count of flushes.

Behaviour:
- Definitions:
  - hitEX(r): r != 0 and r == ex_rw, with ex_regWr=1 or ex_memtoreg=1.
  - hitMEMld(r): r != 0, r == mem_rw, mem_memtoreg=1.
  - srcs = {id_rs} ∪ {id_rt if id_uses_rt}.
- Required stall count N, evaluated in RUN only:
  - id_is_branch=1 and any src hits EX as a load → N=2.
  - else id_is_branch=1 and any src hits EX as an ALU op → N=1.
  - else id_is_branch=1 and any src satisfies hitMEMld → N=1.
  - else id_is_branch=0 and any src hits EX as a load (load-use) → N=1.
  - else N=0.
- FSM states: RUN, STALL2, STALL1. State register updates only on the rising edge of clk.
  - RUN, N=0: outputs pc_write=1, ifid_write=1, idex_bubble=0.
    - ifid_flush=1 iff id_is_jump=1, or id_is_branch=1 and branch_taken=1.
    - Stay in RUN.
  - RUN, N>0: outputs are Mealy (same cycle). pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0.
    - Next state: N=2 → STALL1; N=1 → RUN (re-evaluate next cycle).
  - STALL2: reserved encoding, never entered. If reached, behave as STALL1 and go to STALL1.
  - STALL1: Moore outputs pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0. Unconditionally go to RUN.
- A taken branch seen during a stall cycle is ignored. The flush happens only in the first RUN cycle with N=0.
- Stall takes priority over flush; ifid_flush and idex_bubble are never both 1.
- stall_active = (state != RUN) or (N > 0).
- Counters:
  - stall_cycles increments on each edge where idex_bubble=1.
  - flush_count increments on each edge where ifid_flush=1.
  - Both saturate at 2^CNT_W−1 and do not wrap.
- Reset: the rst_n=0 value is sampled at the edge. While rst_n=0, outputs are forced combinationally to pc_write=0, ifid_write=0, ifid_flush=0, idex_bubble=1, stall_active=0.
- After the reset edge: state=RUN and both counters=0. Reset during STALL1 aborts the stall.
- Register $0 never causes a stall.

Test Plan:
- ALU-to-branch: ex_regWr=1, ex_rw=8, beq rs=8 in ID → one cycle with pc_write=0 and idex_bubble=1. Next cycle (EX bubble) N=0; with branch_taken=1 → ifid_flush=1. Result: stall_cycles=1, flush_count=1.
- Load-to-branch: ex_memtoreg=1, ex_rw=9, bne rt=9, id_uses_rt=1 → stall in RUN then STALL1 (2 cycles). Third cycle N=0 and pc_write=1. stall_cycles=2.
- Load in MEM: mem_memtoreg=1, mem_rw=5, branch rs=5 → exactly 1 stall. The same case with rs=0 and mem_rw=0 → no stall.
- Non-branch load-use: ex_memtoreg=1, ex_rw=4, add rs=4 → 1 stall. The same add with ex_regWr=1 only (ALU producer) → 0 stalls.
- Jump with no hazard → ifid_flush=1 for one cycle, pc_write=1, idex_bubble=0.
- Reset mid-stall: assert rst_n=0 during STALL1 → after the edge, state=RUN and counters=0. Then preload stall_cycles to 16'hFFFF via repeated stalls → the count holds at 16'hFFFF.
